// File: rtl/usb_rcv_pkg.sv
// ============================================================================
// Module      : usb_rcv_pkg
// Description : Shared types and default timing constants for the USB receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_rcv_pkg;

    localparam int USB_CLKS_PER_BIT = 8;
    localparam int USB_SAMPLE_PHASE = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        RUN       = 2'd2
    } rcv_timer_state_t;

endpackage

`default_nettype wire

// File: rtl/rcv_phase_counter.sv
// ============================================================================
// Module      : rcv_phase_counter
// Description : Modulo-MODULO counter with synchronous clear, load-of-1 and enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rcv_phase_counter #(
    parameter int MODULO = 8,
    parameter int WIDTH  = (MODULO > 1) ? $clog2(MODULO) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load1,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Clear dominates load, load dominates the normal increment.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= c_ONE;
        end else if (i_en) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_ONE;
            end
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/rcv_bit_timer.sv
// ============================================================================
// Module      : rcv_bit_timer
// Description : USB receive bit timer; edge-resynchronised sample and byte strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rcv_bit_timer
    import usb_rcv_pkg::*;
#(
    parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int SAMPLE_PHASE = USB_SAMPLE_PHASE
) (
    input  logic clk,
    input  logic rst,
    input  logic rcving,
    input  logic d_edge,
    input  logic skip_bit,
    output logic shift_enable,
    output logic byte_received,
    output logic rcv_active
);

    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] c_SAMPLE = PW'(SAMPLE_PHASE);

    rcv_timer_state_t r_state;
    logic [2:0]       r_bit_cnt;
    logic             r_rcv_active;
    logic [PW-1:0]    w_phase;
    logic             w_in_run;
    logic             w_sync;
    logic             w_at_sample;
    logic             w_clr;
    logic             w_load1;

    assign w_in_run    = (r_state == RUN);
    assign w_at_sample = (w_phase == c_SAMPLE);
    assign w_sync      = (r_state == WAIT_EDGE) && d_edge;

    // An edge landing on the sample phase is not used for resync, so that bit
    // is sampled exactly once.
    assign w_clr   = !rcving || !(w_in_run || w_sync);
    assign w_load1 = w_sync || (w_in_run && d_edge && !w_at_sample);

    rcv_phase_counter #(
        .MODULO (CLKS_PER_BIT),
        .WIDTH  (PW)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_load1 (w_load1),
        .i_en    (w_in_run),
        .o_count (w_phase)
    );

    assign shift_enable  = w_in_run && rcving && w_at_sample && !skip_bit;
    assign byte_received = shift_enable && (r_bit_cnt == 3'd7);
    assign rcv_active    = r_rcv_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 3'd0;
            r_rcv_active <= 1'b0;
        end else if (!rcving) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 3'd0;
            r_rcv_active <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state      <= WAIT_EDGE;
                    r_bit_cnt    <= 3'd0;
                    r_rcv_active <= 1'b0;
                end
                WAIT_EDGE: begin
                    r_bit_cnt <= 3'd0;
                    if (d_edge) begin
                        r_state      <= RUN;
                        r_rcv_active <= 1'b1;
                    end
                end
                RUN: begin
                    r_rcv_active <= 1'b1;
                    if (shift_enable) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_bit_cnt    <= 3'd0;
                    r_rcv_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rcv_bit_timer.sv
// ============================================================================
// Module      : tb_rcv_bit_timer
// Description : Self-checking bench for rcv_bit_timer against a time-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rcv_bit_timer;

    localparam int CPB = 8;
    localparam int SP  = 3;

    logic clk = 1'b0;
    logic rst, rcving, d_edge, skip_bit;
    logic shift_enable, byte_received, rcv_active;

    rcv_bit_timer #(.CLKS_PER_BIT(CPB), .SAMPLE_PHASE(SP)) dut (
        .clk           (clk),
        .rst           (rst),
        .rcving        (rcving),
        .d_edge        (d_edge),
        .skip_bit      (skip_bit),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rcv_active    (rcv_active)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: 0 idle, 1 armed, 2 running; timing is "cycles since last sync edge".
    int m_state = 0;
    int m_ref   = 0;
    int m_bits  = 0;
    int cyc     = 0;
    bit m_chk   = 0;

    int n_se = 0, n_br = 0, last_br = -1;
    logic o_se, o_br, o_act;

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rc, input logic e, input logic s);
        int  el;
        bit  e_act, e_se, e_br;
        rst = r; rcving = rc; d_edge = e; skip_bit = s;
        @(negedge clk);
        el    = (m_state == 2) ? ((cyc - m_ref) % CPB) : 0;
        e_act = (m_state == 2);
        e_se  = e_act && rc && (el == SP) && !s;
        e_br  = e_se && ((m_bits % 8) == 7);
        o_se = shift_enable; o_br = byte_received; o_act = rcv_active;
        if (m_chk) begin
            chk("model_shift_enable", o_se, e_se);
            chk("model_byte_received", o_br, e_br);
            chk("model_rcv_active", o_act, e_act);
        end
        if (o_se) n_se++;
        if (o_br) begin n_br++; last_br = cyc; end
        @(posedge clk);
        if (r || !rc) begin
            m_state = 0; m_bits = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (e) begin m_state = 2; m_ref = cyc; m_bits = 0; end
        end else begin
            if (e_se) m_bits++;
            if (e && el != SP) m_ref = cyc;
        end
        cyc++;
        #1;
    endtask

    task automatic arm_and_sync(output int t0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        t0 = cyc;
        step(0, 1, 1, 0);
    endtask

    typedef struct {
        logic r, rc, e, s;
        logic x_se, x_br, x_act;
    } vec_t;

    vec_t tbl[21];

    initial begin
        int t0, se0, br0;
        rst = 1; rcving = 0; d_edge = 0; skip_bit = 0;
        step(1, 0, 0, 0);
        m_chk = 1;

        // Table: {rst, rcving, d_edge, skip, exp se, exp br, exp active}
        tbl[0]  = '{0,0,0,0, 0,0,0};
        tbl[1]  = '{0,1,1,0, 0,0,0};
        tbl[2]  = '{0,1,0,0, 0,0,0};
        tbl[3]  = '{0,1,1,0, 0,0,0};
        tbl[4]  = '{0,1,0,0, 0,0,1};
        tbl[5]  = '{0,1,0,0, 0,0,1};
        tbl[6]  = '{0,1,0,1, 0,0,1};
        for (int i = 7; i < 14; i++) tbl[i] = '{0,1,0,0, 0,0,1};
        tbl[14] = '{0,1,0,0, 1,0,1};
        tbl[15] = '{0,1,1,0, 0,0,1};
        tbl[16] = '{0,1,0,0, 0,0,1};
        tbl[17] = '{0,1,0,0, 0,0,1};
        tbl[18] = '{0,1,1,0, 1,0,1};
        tbl[19] = '{0,0,0,0, 0,0,1};
        tbl[20] = '{0,0,0,0, 0,0,0};
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].r, tbl[i].rc, tbl[i].e, tbl[i].s);
            chk("tbl_shift_enable", o_se, tbl[i].x_se);
            chk("tbl_byte_received", o_br, tbl[i].x_br);
            chk("tbl_rcv_active", o_act, tbl[i].x_act);
        end

        // Full byte, edges every 8 cycles.
        arm_and_sync(t0);
        br0 = n_br;
        for (int k = 1; k < 64; k++) step(0, 1, (k % 8) == 0, 0);
        chk_int("full_byte_count", n_br - br0, 1);
        chk_int("full_byte_cycle", last_br - t0, 59);

        // Stuffed third bit pushes the byte strobe out by one bit period.
        arm_and_sync(t0);
        br0 = n_br;
        for (int k = 1; k < 72; k++) step(0, 1, 0, (k == 19));
        chk_int("stuffed_byte_count", n_br - br0, 1);
        chk_int("stuffed_byte_cycle", last_br - t0, 67);

        // Resync jitter: edges at +0, +7, +16.
        arm_and_sync(t0);
        se0 = n_se;
        for (int k = 1; k < 21; k++) step(0, 1, (k == 7) || (k == 16), 0);
        chk_int("jitter_sample_count", n_se - se0, 3);

        // Edge exactly at the sample point.
        arm_and_sync(t0);
        se0 = n_se;
        for (int k = 1; k < 13; k++) step(0, 1, (k == 3), 0);
        chk_int("edge_at_sample_count", n_se - se0, 2);

        // Abort after five bits, on what would be the sixth sample.
        arm_and_sync(t0);
        se0 = n_se; br0 = n_br;
        for (int k = 1; k < 43; k++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("abort_strobe_gated", o_se, 1'b0);
        step(0, 0, 0, 0);
        chk("abort_idle", o_act, 1'b0);
        chk_int("abort_sample_count", n_se - se0, 5);
        chk_int("abort_no_byte", n_br - br0, 0);

        // Reset mid-run.
        arm_and_sync(t0);
        for (int k = 1; k < 6; k++) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("reset_active", o_act, 1'b0);
        chk("reset_shift", o_se, 1'b0);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rcv_bit_timer.md
# rcv_bit_timer

Bit-timing controller for the USB receive path. Consumes the per-cycle edge indication from the D+ edge detector and generates a one-cycle `shift_enable` strobe at the sampling point of every received bit, plus a `byte_received` strobe on every eighth shifted bit. It re-synchronises its bit-phase counter on every line transition. It sits between the edge detector and the receive shift register and decoder, and is enabled by the receive control unit.

## Interface
- `CLKS_PER_BIT`, 8: system clocks per USB bit period; must be at least 4.
- `SAMPLE_PHASE`, 3: phase count at which a bit is sampled; range 1..`CLKS_PER_BIT`-1.
- `clk` in 1: single system clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rcving` in 1: receive window from the receive control unit; 0 aborts and idles the timer.
- `d_edge` in 1: one-cycle transition indication from the D+ edge detector.
- `skip_bit` in 1: from the decoder; the bit sampled this cycle is a stuffed bit and must not be shifted or counted.
- `shift_enable` out 1: one-cycle strobe telling the shift register to capture the current bit.
- `byte_received` out 1: one-cycle strobe, coincident with the 8th `shift_enable` of a byte.
- `rcv_active` out 1: high while the timer is in RUN.

## Operation
- States:
  - IDLE: counters cleared.
  - WAIT_EDGE: armed, waiting for the first transition (SYNC start).
  - RUN: bit timing active.
- State transitions:
  - IDLE -> WAIT_EDGE when `rcving`=1.
  - WAIT_EDGE -> RUN on `d_edge`=1; `phase` loads 1.
  - Any state -> IDLE when `rcving`=0.
- `phase` counter (width clog2(`CLKS_PER_BIT`)):
  - In RUN it increments each cycle and wraps from `CLKS_PER_BIT`-1 to 0.
  - In IDLE and WAIT_EDGE it holds 0.
- Resync: `d_edge`=1 in RUN loads `phase`=1, because the edge cycle counts as phase 0.
  - Exception: an edge while `phase`==`SAMPLE_PHASE` is ignored for resync. The sample fires and `phase` increments normally, so no bit is ever double-sampled.
- `shift_enable` = RUN & `rcving` & (`phase`==`SAMPLE_PHASE`) & !`skip_bit`. It is combinational from registered state and inputs.
- `bit_cnt` (3 bits):
  - Increments on each `shift_enable`, wrapping 7->0.
  - Held when `skip_bit` suppresses the sample.
  - Cleared in IDLE and WAIT_EDGE.
- `byte_received` = `shift_enable` & (`bit_cnt`==7).
- Abort: `rcving` falling mid-byte discards the partial count and generates no `byte_received`. Outputs are gated low in the same cycle that `rcving`=0.
- `rcving` and `d_edge` in the same cycle while in IDLE: go to WAIT_EDGE only. That edge is not used for sync.

## Timing
- Reset (`rst`=1 at a clock edge): state IDLE, `phase`=0, `bit_cnt`=0.
  - `shift_enable`, `byte_received` and `rcv_active` are all 0 in the cycle after reset.
  - Reset overrides all other inputs, including mid-byte.
- Edge-to-sample latency: `d_edge` in cycle t produces `shift_enable` in cycle t+`SAMPLE_PHASE` (t+3 at defaults), provided no further edge or abort occurs.
- Free-running without edges, samples repeat every `CLKS_PER_BIT` cycles.
- `rcv_active` is registered state. It rises the cycle after the sync edge and falls the cycle after `rcving`=0.
- Edge at phase p≠`SAMPLE_PHASE`: the next sample is `SAMPLE_PHASE` cycles after the edge.
  - An edge after the sample point shortens the current bit period.
  - An edge before the sample point delays the sample.
- No handshake: the strobes are fire-and-forget, and consumers must act in the strobe cycle.

## Structure
- Shared package `usb_rcv_pkg` holds:
  - enum `rcv_timer_state_t` {IDLE, WAIT_EDGE, RUN};
  - localparams `USB_CLKS_PER_BIT`=8 and `USB_SAMPLE_PHASE`=3, used as the module defaults.
- Sub-module `rcv_phase_counter`: parameterised modulo counter with synchronous clear, load-of-1 and enable, used for `phase`.
  - `bit_cnt` stays inline in `rcv_bit_timer`.

## Test plan
- Sync and sample: reset, set `rcving`=1, pulse `d_edge` at cycle 10 -> `rcv_active`=1 at cycle 11; `shift_enable` at cycles 13, 21, 29 …
- Full byte: 8 bits with an edge every 8 cycles, first edge at cycle 10 -> `byte_received` exactly once, with the 8th `shift_enable` at cycle 69; `bit_cnt` back to 0.
- Resync jitter: edges at cycles 10, 17 and 26 -> `shift_enable` at cycles 13, 20 and 29; no duplicate or missing strobe.
- Edge at the sample point: sync edge at cycle 10, second edge at cycle 13 -> single `shift_enable` at 13, next at 21.
- Stuffed bit: `skip_bit`=1 during the 3rd sample -> no `shift_enable` that cycle; `byte_received` occurs 8 cycles later than in the full-byte case.
- Abort and reset: drop `rcving` after 5 bits -> strobes stop in the same cycle, IDLE the next cycle, no `byte_received`. Assert `rst` mid-RUN -> all outputs 0 in the following cycle.
